multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM for the multicycle RV32I core: sequences fetch, decode, execute, memory and writeback over the shared single-port memory, PC, instruction register, register file and ALU inside `top`. It decodes the 7-bit opcode of the latched instruction and drives all datapath enables and mux selects as one-hot-per-cycle control. It also maintains a retired-instruction counter and a halt flag that the simulation bench uses to end a program run.

## Interface
- No parameters. The state encoding is internal.
- `clk` in 1: system clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `opcode` in 7: `instruction[6:0]` from the instruction register.
- `branch_taken` in 1: comparator result for the current branch. Valid in BRANCH.
- `pc_write_en` out 1: load PC.
- `pc_src_sel` out 1: PC source. 0 = combinational ALU output, 1 = registered ALU result.
- `oldpc_write_en` out 1: latch the PC of the current instruction.
- `ir_write_en` out 1: latch memory read data into the instruction register.
- `mem_addr_sel` out 1: memory address source. 0 = PC, 1 = registered ALU result.
- `memory_write_en` out 1: store strobe.
- `register_write_en` out 1: register file write.
- `result_sel` out 2: register file write data. 0 = ALU result register, 1 = memory data, 2 = PC.
- `alu_a_sel` out 2: ALU input A. 0 = PC, 1 = rs1, 2 = old PC, 3 = zero.
- `alu_b_sel` out 2: ALU input B. 0 = rs2, 1 = immediate, 2 = constant 4.
- `alu_op` out 2: 0 = add, 1 = funct3/funct7 decoded, 2 = branch compare.
- `retire` out 1: one-cycle pulse in the final state of each instruction.
- `instret` out 32: retired-instruction count.
- `halted` out 1: high in HALT.

## Operation
- States: FETCH, FETCH_WAIT, DECODE, EXEC_R, EXEC_I, EXEC_LUI, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JAL, JALR, HALT.
- Any output not listed for a state is 0.
- FETCH: `mem_addr_sel=0`. Next state is FETCH_WAIT.
- FETCH_WAIT: `ir_write_en`, `oldpc_write_en`, `pc_write_en` with `pc_src_sel=0`, A=PC, B=4, op add. Next state is DECODE.
- DECODE: A=old PC, B=imm, op add. This precomputes the branch/JAL/AUIPC target into the ALU result register. Next state by opcode:
  - 0x33 → EXEC_R
  - 0x13 → EXEC_I
  - 0x37 → EXEC_LUI
  - 0x17 → ALU_WB
  - 0x03 or 0x23 → MEM_ADDR
  - 0x63 → BRANCH
  - 0x6F → JAL
  - 0x67 → JALR
  - any other value, including 0x73 (ecall/ebreak = program end) → HALT
- EXEC_R: A=rs1, B=rs2, op 1. Next state is ALU_WB.
- EXEC_I: A=rs1, B=imm, op 1. Next state is ALU_WB.
- EXEC_LUI: A=zero, B=imm, op add. Next state is ALU_WB.
- ALU_WB: `register_write_en`, `result_sel=0`, `retire`. Next state is FETCH.
- MEM_ADDR: A=rs1, B=imm, op add. Next state is MEM_READ if opcode is 0x03, otherwise MEM_WRITE.
- MEM_READ: `mem_addr_sel=1`. Next state is MEM_WB.
- MEM_WB: `register_write_en`, `result_sel=1`, `retire`. Next state is FETCH.
- MEM_WRITE: `mem_addr_sel=1`, `memory_write_en`, `retire`. Next state is FETCH.
- BRANCH: A=rs1, B=rs2, op 2, `retire`. `pc_write_en = branch_taken`; this is the only Mealy output. `pc_src_sel=1`. Next state is FETCH.
- JAL: `pc_write_en`, `pc_src_sel=1`, `register_write_en`, `result_sel=2`, `retire`. rd receives the pre-update PC, which equals old PC + 4. Next state is FETCH.
- JALR: A=rs1, B=imm, op add, `pc_write_en`, `pc_src_sel=0`, `register_write_en`, `result_sel=2`, `retire`. The datapath clears target bit 0. Next state is FETCH.
- HALT: all enables 0, `halted=1`. The FSM stays in HALT until reset.
- `opcode` is sampled only in DECODE and MEM_ADDR. The IR is stable in both states because `ir_write_en` is asserted only in FETCH_WAIT.
- `instret` increments by 1 on every cycle with `retire=1`. It wraps from 0xFFFFFFFF to 0x00000000.

## Timing
- Reset, sampled at a clock edge, puts the FSM in FETCH next cycle and sets `instret=0`.
- While `reset` is high, all enables, `retire` and `halted` are forced to 0. The selects read 0 during this time.
- Reset mid-instruction aborts the instruction. A store in MEM_WRITE does not write, and no retire is counted.
- The first cycle after reset release is FETCH. That cycle's `mem_addr_sel=0` produces the read of PC.
- Memory read data is valid the cycle after the address is presented. This is why FETCH_WAIT and MEM_WB each follow a one-cycle address state.
- Latency, FETCH through the retire cycle inclusive:
  - R, I, LUI: 5 cycles
  - AUIPC: 4 cycles
  - load: 6 cycles
  - store: 5 cycles
  - branch, JAL, JALR: 4 cycles
- HALT is entered 3 cycles after FETCH. `halted` is high from the 4th cycle on.
- At no cycle are `pc_write_en` and `ir_write_en` both asserted with `pc_src_sel=1`.
- `register_write_en` and `memory_write_en` are never asserted in the same cycle.

## Test plan
- Reset: hold `reset` for 2 cycles, release, opcode 0x33 → state FETCH, all enables 0 during reset, `instret`=0; `register_write_en` pulses exactly in cycle 5 after release; `instret`=1 afterwards.
- Load 0x03 → state sequence FETCH, FETCH_WAIT, DECODE, MEM_ADDR, MEM_READ (`mem_addr_sel=1`), MEM_WB (`result_sel=1`, write); 6 cycles. Store 0x23 → `memory_write_en` asserted for exactly 1 cycle, in cycle 5.
- Branch 0x63 with `branch_taken=0` → no `pc_write_en` in BRANCH. Repeat with `branch_taken=1` → `pc_write_en=1` and `pc_src_sel=1` in cycle 4.
- JAL 0x6F → cycle 4 asserts `pc_write_en`, `register_write_en`, `result_sel=2` together. JALR 0x67 → same, with `pc_src_sel=0`, `alu_a_sel=1`.
- Opcode 0x73, then 0x00 after reset → `halted=1` from cycle 4 onward, enables stay 0 for 100 cycles, `instret` unchanged. Reset → resumes at FETCH.
- Reset asserted during MEM_WRITE → `memory_write_en` is 0 in that cycle, `instret` is 0 afterwards. Preload `instret`=0xFFFFFFFF via a forced value, retire once → `instret` is 0x00000000.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch, decode, execute, memory and
// writeback, drives datapath enables/selects, and keeps the retired-instruction count.
module multicycle_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        branch_taken,
   output logic        pc_write_en,
   output logic        pc_src_sel,
   output logic        oldpc_write_en,
   output logic        ir_write_en,
   output logic        mem_addr_sel,
   output logic        memory_write_en,
   output logic        register_write_en,
   output logic [1:0]  result_sel,
   output logic [1:0]  alu_a_sel,
   output logic [1:0]  alu_b_sel,
   output logic [1:0]  alu_op,
   output logic        retire,
   output logic [31:0] instret,
   output logic        halted
);

   typedef enum logic [3:0] {
      StFetch, StFetchWait, StDecode, StExecR, StExecI, StExecLui, StMemAddr, StMemRead,
      StMemWb, StMemWrite, StAluWb, StBranch, StJal, StJalr, StHalt
   } state_e;

   localparam logic [6:0] OpR      = 7'h33;
   localparam logic [6:0] OpI      = 7'h13;
   localparam logic [6:0] OpLui    = 7'h37;
   localparam logic [6:0] OpAuipc  = 7'h17;
   localparam logic [6:0] OpLoad   = 7'h03;
   localparam logic [6:0] OpStore  = 7'h23;
   localparam logic [6:0] OpBranch = 7'h63;
   localparam logic [6:0] OpJal    = 7'h6F;
   localparam logic [6:0] OpJalr   = 7'h67;

   state_e      state_q, state_d;
   logic [31:0] instret_q, instret_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFetch;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch:     state_d = StFetchWait;
         StFetchWait: state_d = StDecode;
         StDecode: begin
            unique case (opcode)
               OpR:             state_d = StExecR;
               OpI:             state_d = StExecI;
               OpLui:           state_d = StExecLui;
               OpAuipc:         state_d = StAluWb;
               OpLoad, OpStore: state_d = StMemAddr;
               OpBranch:        state_d = StBranch;
               OpJal:           state_d = StJal;
               OpJalr:          state_d = StJalr;
               default:         state_d = StHalt;
            endcase
         end
         StExecR, StExecI, StExecLui: state_d = StAluWb;
         StMemAddr:   state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
         StMemRead:   state_d = StMemWb;
         StHalt:      state_d = StHalt;
         default:     state_d = StFetch;
      endcase
   end

   always_comb begin
      pc_write_en       = 1'b0;
      pc_src_sel        = 1'b0;
      oldpc_write_en    = 1'b0;
      ir_write_en       = 1'b0;
      mem_addr_sel      = 1'b0;
      memory_write_en   = 1'b0;
      register_write_en = 1'b0;
      result_sel        = 2'd0;
      alu_a_sel         = 2'd0;
      alu_b_sel         = 2'd0;
      alu_op            = 2'd0;
      retire            = 1'b0;
      halted            = 1'b0;
      unique case (state_q)
         StFetchWait: begin
            ir_write_en    = 1'b1;
            oldpc_write_en = 1'b1;
            pc_write_en    = 1'b1;
            alu_b_sel      = 2'd2;
         end
         StDecode: begin
            alu_a_sel = 2'd2;
            alu_b_sel = 2'd1;
         end
         StExecR: begin
            alu_a_sel = 2'd1;
            alu_op    = 2'd1;
         end
         StExecI: begin
            alu_a_sel = 2'd1;
            alu_b_sel = 2'd1;
            alu_op    = 2'd1;
         end
         StExecLui: begin
            alu_a_sel = 2'd3;
            alu_b_sel = 2'd1;
         end
         StAluWb: begin
            register_write_en = 1'b1;
            retire            = 1'b1;
         end
         StMemAddr: begin
            alu_a_sel = 2'd1;
            alu_b_sel = 2'd1;
         end
         StMemRead: mem_addr_sel = 1'b1;
         StMemWb: begin
            register_write_en = 1'b1;
            result_sel        = 2'd1;
            retire            = 1'b1;
         end
         StMemWrite: begin
            mem_addr_sel    = 1'b1;
            memory_write_en = 1'b1;
            retire          = 1'b1;
         end
         StBranch: begin
            alu_a_sel   = 2'd1;
            alu_op      = 2'd2;
            pc_write_en = branch_taken;
            pc_src_sel  = 1'b1;
            retire      = 1'b1;
         end
         StJal: begin
            pc_write_en       = 1'b1;
            pc_src_sel        = 1'b1;
            register_write_en = 1'b1;
            result_sel        = 2'd2;
            retire            = 1'b1;
         end
         StJalr: begin
            alu_a_sel         = 2'd1;
            alu_b_sel         = 2'd1;
            pc_write_en       = 1'b1;
            register_write_en = 1'b1;
            result_sel        = 2'd2;
            retire            = 1'b1;
         end
         StHalt:  halted = 1'b1;
         default: ;
      endcase
      // Reset masks everything so an interrupted store never writes or retires.
      if (reset) begin
         pc_write_en       = 1'b0;
         pc_src_sel        = 1'b0;
         oldpc_write_en    = 1'b0;
         ir_write_en       = 1'b0;
         mem_addr_sel      = 1'b0;
         memory_write_en   = 1'b0;
         register_write_en = 1'b0;
         result_sel        = 2'd0;
         alu_a_sel         = 2'd0;
         alu_b_sel         = 2'd0;
         alu_op            = 2'd0;
         retire            = 1'b0;
         halted            = 1'b0;
      end
   end

   always_comb begin
      instret_d = instret_q + {31'd0, retire};
   end

   assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors are queued
// with their stimulus, then popped and compared against the DUT one cycle at a time.
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  opcode = 7'h33;
   logic        branch_taken = 1'b0;
   logic        pc_write_en, pc_src_sel, oldpc_write_en, ir_write_en, mem_addr_sel;
   logic        memory_write_en, register_write_en, retire, halted;
   logic [1:0]  result_sel, alu_a_sel, alu_b_sel, alu_op;
   logic [31:0] instret;

   multicycle_controller dut (
      .clk               (clk),
      .reset             (reset),
      .opcode            (opcode),
      .branch_taken      (branch_taken),
      .pc_write_en       (pc_write_en),
      .pc_src_sel        (pc_src_sel),
      .oldpc_write_en    (oldpc_write_en),
      .ir_write_en       (ir_write_en),
      .mem_addr_sel      (mem_addr_sel),
      .memory_write_en   (memory_write_en),
      .register_write_en (register_write_en),
      .result_sel        (result_sel),
      .alu_a_sel         (alu_a_sel),
      .alu_b_sel         (alu_b_sel),
      .alu_op            (alu_op),
      .retire            (retire),
      .instret           (instret),
      .halted            (halted)
   );

   always #5 clk = ~clk;

   logic [16:0] obs;
   assign obs = {pc_write_en, pc_src_sel, oldpc_write_en, ir_write_en, mem_addr_sel,
                 memory_write_en, register_write_en, result_sel, alu_a_sel, alu_b_sel,
                 alu_op, retire, halted};

   typedef struct {
      logic        rst;
      logic [6:0]  opc;
      logic        taken;
      logic [16:0] exp;
   } ent_t;

   ent_t        sb[$];
   ent_t        ent;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_instret = '0;

   function automatic logic [16:0] mk(input logic pcw, input logic pcs, input logic opc,
                                      input logic ir, input logic mas, input logic mwe,
                                      input logic rwe, input logic [1:0] rs,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] op, input logic ret, input logic hlt);
      return {pcw, pcs, opc, ir, mas, mwe, rwe, rs, a, b, op, ret, hlt};
   endfunction

   task automatic push(input logic rst, input logic [6:0] opc, input logic tk,
                       input logic [16:0] e);
      ent_t x;
      x.rst = rst; x.opc = opc; x.taken = tk; x.exp = e;
      sb.push_back(x);
   endtask

   // Expected control sequence for one instruction, written from the state table.
   task automatic push_instr(input logic [6:0] op, input logic tk);
      push(0, op, tk, 17'd0);                                          // FETCH
      push(0, op, tk, mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0));      // FETCH_WAIT
      push(0, op, tk, mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));      // DECODE
      case (op)
         7'h33: begin
            push(0, op, tk, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
            push(0, op, tk, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
         end
         7'h13: begin
            push(0, op, tk, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
            push(0, op, tk, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
         end
         7'h37: begin
            push(0, op, tk, mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
            push(0, op, tk, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
         end
         7'h17: push(0, op, tk, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
         7'h03: begin
            push(0, op, tk, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
            push(0, op, tk, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            push(0, op, tk, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
         end
         7'h23: begin
            push(0, op, tk, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
            push(0, op, tk, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
         end
         7'h63: push(0, op, tk, mk(tk, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0));
         7'h6F: push(0, op, tk, mk(1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0));
         7'h67: push(0, op, tk, mk(1, 0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 1, 0));
         default: push(0, op, tk, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      endcase
   endtask

   task automatic test_reset();
      int cyc = 0;
      push(1, 7'h33, 0, 17'd0);
      push(1, 7'h33, 0, 17'd0);
      push_instr(7'h33, 0);
      while (sb.size() > 0) begin
         ent = sb.pop_front();
         reset = ent.rst; opcode = ent.opc; branch_taken = ent.taken;
         #1;
         n_checks++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL reset cyc %0d: ctl got %h want %h", cyc, obs, ent.exp);
         end
         if (!ent.rst) begin
            n_checks++;
            if (instret !== exp_instret) begin
               n_fail++;
               $display("FAIL reset_instret cyc %0d: got %h want %h", cyc, instret, exp_instret);
            end
         end
         if (ent.rst) exp_instret = '0;
         else if (ent.exp[1]) exp_instret = exp_instret + 1;
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_alu_and_mem();
      int cyc = 0;
      push_instr(7'h13, 0);
      push_instr(7'h37, 0);
      push_instr(7'h17, 0);
      push_instr(7'h03, 0);
      push_instr(7'h23, 0);
      while (sb.size() > 0) begin
         ent = sb.pop_front();
         reset = ent.rst; opcode = ent.opc; branch_taken = ent.taken;
         #1;
         n_checks++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL alu_mem cyc %0d: ctl got %h want %h", cyc, obs, ent.exp);
         end
         n_checks++;
         if (instret !== exp_instret) begin
            n_fail++;
            $display("FAIL alu_mem_instret cyc %0d: got %h want %h", cyc, instret, exp_instret);
         end
         if (ent.exp[1]) exp_instret = exp_instret + 1;
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back_ctrl();
      int cyc = 0;
      push_instr(7'h63, 0);
      push_instr(7'h63, 1);
      push_instr(7'h6F, 0);
      push_instr(7'h67, 1);
      push_instr(7'h33, 1);
      while (sb.size() > 0) begin
         ent = sb.pop_front();
         reset = ent.rst; opcode = ent.opc; branch_taken = ent.taken;
         #1;
         n_checks++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL ctrl_flow cyc %0d: ctl got %h want %h", cyc, obs, ent.exp);
         end
         n_checks++;
         if (instret !== exp_instret) begin
            n_fail++;
            $display("FAIL ctrl_flow_instret cyc %0d: got %h want %h", cyc, instret, exp_instret);
         end
         if (ent.exp[1]) exp_instret = exp_instret + 1;
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_halt();
      int cyc = 0;
      logic [16:0] vhalt;
      vhalt = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      push_instr(7'h73, 0);
      repeat (100) push(0, 7'h73, 0, vhalt);
      push(1, 7'h00, 0, 17'd0);
      push_instr(7'h00, 0);
      repeat (5) push(0, 7'h00, 0, vhalt);
      push(1, 7'h33, 0, 17'd0);
      push_instr(7'h33, 0);
      while (sb.size() > 0) begin
         ent = sb.pop_front();
         reset = ent.rst; opcode = ent.opc; branch_taken = ent.taken;
         #1;
         n_checks++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL halt cyc %0d: ctl got %h want %h", cyc, obs, ent.exp);
         end
         if (!ent.rst) begin
            n_checks++;
            if (instret !== exp_instret) begin
               n_fail++;
               $display("FAIL halt_instret cyc %0d: got %h want %h", cyc, instret, exp_instret);
            end
         end
         if (ent.rst) exp_instret = '0;
         else if (ent.exp[1]) exp_instret = exp_instret + 1;
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_store_abort();
      int cyc = 0;
      push_instr(7'h23, 0);
      void'(sb.pop_back());                  // MEM_WRITE cycle is replaced by a reset cycle
      push(1, 7'h23, 0, 17'd0);
      push_instr(7'h03, 0);
      while (sb.size() > 0) begin
         ent = sb.pop_front();
         reset = ent.rst; opcode = ent.opc; branch_taken = ent.taken;
         #1;
         n_checks++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL store_abort cyc %0d: ctl got %h want %h", cyc, obs, ent.exp);
         end
         if (!ent.rst) begin
            n_checks++;
            if (instret !== exp_instret) begin
               n_fail++;
               $display("FAIL store_abort_instret cyc %0d: got %h want %h", cyc, instret,
                        exp_instret);
            end
         end
         if (ent.rst) exp_instret = '0;
         else if (ent.exp[1]) exp_instret = exp_instret + 1;
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_instret_wrap();
      int cyc = 0;
      push_instr(7'h33, 0);
      push_instr(7'h6F, 0);
      while (sb.size() > 0) begin
         ent = sb.pop_front();
         reset = ent.rst; opcode = ent.opc; branch_taken = ent.taken;
         if (cyc == 1) begin
            force dut.instret_q = 32'hFFFF_FFFF;
            exp_instret = 32'hFFFF_FFFF;
         end
         if (cyc == 2) release dut.instret_q;
         #1;
         n_checks++;
         if (obs !== ent.exp) begin
            n_fail++;
            $display("FAIL wrap cyc %0d: ctl got %h want %h", cyc, obs, ent.exp);
         end
         n_checks++;
         if (instret !== exp_instret) begin
            n_fail++;
            $display("FAIL wrap_instret cyc %0d: got %h want %h", cyc, instret, exp_instret);
         end
         if (ent.exp[1]) exp_instret = exp_instret + 1;
         cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_alu_and_mem();
      test_back_to_back_ctrl();
      test_halt();
      test_store_abort();
      test_instret_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
